multiplier: RTL and testbench
=============================

// Module: multiplier
// PURPOSE
//  - Sequential unsigned shift-add multiplier: N-bit a x N-bit b -> 2N-bit product s.
//  - Arithmetic building block of the ALU, beside the adder.
//  - One partial product per clock, fixed latency, start/done handshake.
// PARAMETERS
//  - N  default 4  operand width in bits (N >= 2); product width is 2N.
// PORTS
//  - clk    in   1     rising-edge clock; the block's only clock.
//  - rst    in   1     synchronous, active-high reset.
//  - start  in   1     request a multiply; sampled only while idle.
//  - a      in   N     multiplicand, unsigned; captured on an accepted start.
//  - b      in   N     multiplier, unsigned; captured on an accepted start.
//  - busy   out  1     high from the cycle after an accepted start until done.
//  - done   out  1     one-cycle pulse; s is valid in the same cycle.
//  - s      out  2N    product a*b; held stable until the next accepted start.
//  - ovf    out  1     present only with MULT_OVF_EN (see CONFIGURATION).
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Reset values: busy=0, done=0, s=0, ovf=0. State returns to IDLE.
//    Internal registers are cleared.
//  - FSM states:
//    - IDLE: start=1 latches a and b, clears the accumulator and count, goes to RUN.
//    - RUN: runs N cycles. Each cycle:
//      - if the multiplier LSB is 1, add the multiplicand into the upper half of the accumulator;
//      - shift right by 1, keeping the carry.
//      - The count reaching N-1 moves the FSM to DONE.
//    - DONE: lasts one cycle. s <= accumulator, done=1, then back to IDLE.
//  - Latency: start sampled at edge T gives done=1 and s valid after edge T+N+1.
//    For N=4, that is 5 cycles.
//  - A back-to-back start is accepted in the cycle right after done (IDLE).
//  - start while busy or in DONE is ignored. The in-flight operation and its operands are unaffected.
//  - a and b may change freely after acceptance; only the latched copies are used.
//  - All arithmetic is unsigned and mod 2^(2N).
//    - The product is always exact; (2^N-1)^2 fits in 2N bits.
//    - The adder needs N+1 bits to keep the carry.
//  - Zero operands still take the full N cycles; there is no early termination.
//  - rst asserted during RUN or DONE aborts at the next edge:
//    - no done pulse;
//    - s is forced to 0.
//  - rst overrides start in the same cycle.
//  - s changes only in DONE (new product) or on reset.
// CONFIGURATION
//  - Macro MULT_OVF_EN.
//  - Defined:
//    - the ovf output port exists;
//    - ovf is registered with s in DONE;
//    - ovf = 1 iff s[2N-1:N] != 0, i.e. the product does not fit in N bits;
//    - ovf holds with s and resets to 0.
//  - Undefined: there is no ovf port and no logic for it. All other behaviour is identical.
// STRUCTURE
//  - Package mult_pkg:
//    - state typedef {IDLE, RUN, DONE};
//    - function cnt_width(N) = $clog2(N);
//    - constant default N = 4.
//  - One natural sub-module, mult_datapath:
//    - holds the operand, accumulator and count registers;
//    - contains the (N+1)-bit adder and the shifter;
//    - is controlled by load/step/capture strobes from the top-level FSM.
//  - The top level holds the FSM, the handshake outputs and the MULT_OVF_EN logic.
// TESTING (N=4; check s on the done cycle and hold until the next start)
//  - Zero: a=0, b=0 -> s=0, ovf=0. done exactly 5 cycles after start.
//  - Products: a=3, b=6 -> s=18, ovf=1 (18 > 15). a=9, b=9 -> s=81.
//  - Unsigned wrap inputs:
//    - a=5, b=4'hF (-1) -> s=75;
//    - a=4'hB (-5), b=1 -> s=11, ovf=0.
//  - Max: a=15, b=15 -> s=225.
//    - Sweep all 256 pairs against a reference model.
//    - Back-to-back starts, one issued in the cycle after each done.
//  - Protocol:
//    - start pulsed during RUN with other operands -> ignored, first product returned;
//    - operands changed after acceptance -> no effect.
//  - Reset: rst asserted mid-RUN -> busy, done and s go to 0 at the next edge, no done pulse.
//    - A new start then completes normally.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-add multiplier.
package mult_pkg;

    localparam int unsigned N_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mult_datapath.sv
// Operand, accumulator and step-count registers of the shift-add multiplier,
// driven by load/step strobes from the controlling FSM.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] acc_o,
    output logic           last_o
);

    localparam int unsigned CW = cnt_width(N);

    logic [N-1:0]   mcand_q,  mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [2*N-1:0] acc_q,    acc_d;
    logic [CW-1:0]  cnt_q,    cnt_d;
    logic [N:0]     addend;
    logic [N:0]     sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Upper half plus the multiplicand keeps its carry in bit N; that carry
    // becomes the top bit of the accumulator after the right shift.
    always_comb begin
        addend   = mplier_q[0] ? {1'b0, mcand_q} : '0;
        sum      = {1'b0, acc_q[2*N-1:N]} + addend;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step_i) begin
            acc_d    = {sum, acc_q[N-1:1]};
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
        end
    end

    assign acc_o  = acc_q;
    assign last_o = (cnt_q == CW'(N - 1));

endmodule

// File: rtl/multiplier.sv
// Sequential unsigned shift-add multiplier with start/done handshake.
// Optional overflow flag is built only when MULT_OVF_EN is defined.
module multiplier
    import mult_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] s
`ifdef MULT_OVF_EN
    ,
    output logic           ovf
`endif
);

    state_t         state_q, state_d;
    logic           load, step, capture, last;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] s_q;
    logic           done_q;

    mult_datapath #(
        .N (N)
    ) u_datapath (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .step_i (step),
        .a_i    (a),
        .b_i    (b),
        .acc_o  (acc),
        .last_o (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load    = (state_q == IDLE) && start;
        step    = (state_q == RUN);
        capture = (state_q == DONE);
        busy    = (state_q != IDLE);
    end

    // done and s are registered on the DONE edge so they appear together.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= capture;
            if (capture) begin
                s_q <= acc;
            end
        end
    end

    assign s    = s_q;
    assign done = done_q;

`ifdef MULT_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (capture) begin
            ovf_q <= |acc[2*N-1:N];
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_multiplier.sv
// Directed and sweep bench for the N=4 multiplier (handles both MULT_OVF_EN builds).
module tb_multiplier;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a, b;
    logic         busy, done;
    logic [2*N-1:0] s;
`ifdef MULT_OVF_EN
    logic         ovf;
`endif

    int unsigned tests  = 0;
    int unsigned failed = 0;

    multiplier #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s)
`ifdef MULT_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] s;
        logic           ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Issues one start, then waits (bounded) for done; returns edges from accept to done.
    task automatic do_op(input logic [N-1:0] va, input logic [N-1:0] vb, output int unsigned lat);
        @(negedge clk);
        a     = va;
        b     = vb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int unsigned lat;
        int unsigned wait_cyc;
        int unsigned saw_done;

        vecs[0] = '{4'd0,  4'd0,  8'd0,   1'b0};
        vecs[1] = '{4'd3,  4'd6,  8'd18,  1'b1};
        vecs[2] = '{4'd9,  4'd9,  8'd81,  1'b1};
        vecs[3] = '{4'd5,  4'hF,  8'd75,  1'b1};
        vecs[4] = '{4'hB,  4'd1,  8'd11,  1'b0};
        vecs[5] = '{4'd15, 4'd15, 8'd225, 1'b1};
        vecs[6] = '{4'd1,  4'd1,  8'd1,   1'b0};
        vecs[7] = '{4'd15, 4'd0,  8'd0,   1'b0};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_s",    s,    0);
`ifdef MULT_OVF_EN
        check("reset_ovf",  ovf,  0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d_latency", i), lat, 5);
            check($sformatf("vec%0d_s", i), s, vecs[i].s);
`ifdef MULT_OVF_EN
            check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
`endif
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), done, 0);
            check($sformatf("vec%0d_s_hold", i), s, vecs[i].s);
            check($sformatf("vec%0d_idle", i), busy, 0);
        end

        // Full sweep, each start issued in the cycle right after the previous done.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                do_op(4'(ia), 4'(ib), lat);
                check($sformatf("sweep_%0dx%0d_lat", ia, ib), lat, 5);
                check($sformatf("sweep_%0dx%0d_s", ia, ib), s, ia * ib);
`ifdef MULT_OVF_EN
                check($sformatf("sweep_%0dx%0d_ovf", ia, ib), ovf, (ia * ib > 15) ? 1 : 0);
`endif
            end
        end
        @(negedge clk);

        // start held high with other operands through RUN and DONE is ignored.
        @(negedge clk);
        a     = 4'd3;
        b     = 4'd6;
        start = 1'b1;
        @(negedge clk);
        a   = 4'd15;
        b   = 4'd15;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            a = 4'(lat);
        end
        start = 1'b0;
        check("protocol_latency", lat, 5);
        check("protocol_s", s, 18);
        @(negedge clk);
        check("protocol_no_restart", busy, 0);
        check("protocol_s_hold", s, 18);

        // Reset mid-RUN aborts with no done pulse and clears s.
        @(negedge clk);
        a     = 4'd9;
        b     = 4'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_s",    s,    0);
        saw_done = 0;
        for (wait_cyc = 0; wait_cyc < 8; wait_cyc++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check("abort_no_done", saw_done, 0);

        do_op(4'd7, 4'd5, lat);
        check("after_abort_lat", lat, 5);
        check("after_abort_s", s, 35);
`ifdef MULT_OVF_EN
        check("after_abort_ovf", ovf, 1);
`endif

        // rst wins over start in the same cycle.
        @(negedge clk);
        a     = 4'd2;
        b     = 4'd2;
        start = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        check("rst_over_start_busy", busy, 0);
        check("rst_over_start_s", s, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
